// File: rtl/pipe_seq_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings and
// per-stage bit positions within the stage_vld / stage_en vectors.
package pipe_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;
    localparam int NUM_STG = 5;

endpackage : pipe_seq_pkg

// File: rtl/pipe_seq_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Used for the stall-length counter and the optional statistics counters.
module pipe_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Count up while enabled, stick at all-ones, clear on request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule : pipe_sat_cnt

// File: rtl/pipe_seq_ctrl.sv
// Five-stage pipeline sequencer: RUN / STALL / FLUSH / HALT.
// Optional statistics counters are built only when PIPE_SEQ_STATS_EN is
// defined; otherwise stall_cycles and flush_events are constant zero.
module pipe_seq_ctrl
    import pipe_seq_pkg::*;
#(
    parameter int STALL_LIMIT = 16,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_vld,
    input  logic              freeze_in,
    input  logic              flush_in,
    input  logic              resolved_in,
    input  logic              halt_req,
    output logic [4:0]        stage_vld,
    output logic [4:0]        stage_en,
    output logic              pc_we,
    output logic [1:0]        seq_state,
    output logic              stall_timeout,
    output logic              halt_done,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_events
);

    // Counter value seen on the last permitted STALL cycle.
    localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

    seq_state_t state_r;
    seq_state_t next_s;
    logic [4:0] stage_vld_r;
    logic [4:0] vld_next_s;
    logic [4:0] stage_en_s;
    logic       pc_we_s;
    logic [7:0] stall_cnt_s;
    logic       stall_en_s;
    logic       stall_clr_s;
    logic       stall_hit_s;

    assign stall_hit_s = (stall_cnt_s == STALL_LAST);

    // Next-state selection with the per-state priority order.
    always_comb begin
        next_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (flush_in)       next_s = ST_FLUSH;
                else if (freeze_in) next_s = ST_STALL;
                else if (halt_req)  next_s = ST_HALT;
                else                next_s = ST_RUN;
            end
            ST_STALL: begin
                if (flush_in)                        next_s = ST_FLUSH;
                else if (stall_hit_s)                next_s = ST_FLUSH;
                else if (resolved_in && !freeze_in)  next_s = ST_RUN;
                else                                 next_s = ST_STALL;
            end
            ST_FLUSH: begin
                if (flush_in) next_s = ST_FLUSH;
                else          next_s = ST_RUN;
            end
            ST_HALT: begin
                if (flush_in)       next_s = ST_FLUSH;
                else if (!halt_req) next_s = ST_RUN;
                else                next_s = ST_HALT;
            end
            default: next_s = ST_RUN;
        endcase
    end

    // Per-state enables, PC strobe and next stage-valid vector.
    always_comb begin
        stage_en_s = 5'b11111;
        pc_we_s    = 1'b0;
        vld_next_s = stage_vld_r;
        case (state_r)
            ST_RUN: begin
                stage_en_s = 5'b11111;
                pc_we_s    = fetch_vld;
                vld_next_s = {stage_vld_r[3:0], fetch_vld};
            end
            ST_STALL: begin
                // IF/ID hold, bubble into EX, MEM/WB drain forward.
                stage_en_s          = 5'b11100;
                pc_we_s             = 1'b0;
                vld_next_s[STG_IF]  = stage_vld_r[STG_IF];
                vld_next_s[STG_ID]  = stage_vld_r[STG_ID];
                vld_next_s[STG_EX]  = 1'b0;
                vld_next_s[STG_MEM] = stage_vld_r[STG_EX];
                vld_next_s[STG_WB]  = stage_vld_r[STG_MEM];
            end
            ST_FLUSH: begin
                // Redirect: squash the front three stages.
                stage_en_s          = 5'b11111;
                pc_we_s             = 1'b1;
                vld_next_s[STG_IF]  = 1'b0;
                vld_next_s[STG_ID]  = 1'b0;
                vld_next_s[STG_EX]  = 1'b0;
                vld_next_s[STG_MEM] = stage_vld_r[STG_EX];
                vld_next_s[STG_WB]  = stage_vld_r[STG_MEM];
            end
            ST_HALT: begin
                stage_en_s = 5'b11111;
                pc_we_s    = 1'b0;
                vld_next_s = {stage_vld_r[3:0], 1'b0};
            end
            default: begin
                stage_en_s = 5'b11111;
                pc_we_s    = 1'b0;
                vld_next_s = 5'b00000;
            end
        endcase
    end

    // Sequencer state and stage-valid shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            stage_vld_r <= 5'b00000;
        end else begin
            state_r     <= next_s;
            stage_vld_r <= vld_next_s;
        end
    end

    // Stall length counter: runs in STALL, zeroed whenever STALL is left.
    assign stall_en_s  = (state_r == ST_STALL);
    assign stall_clr_s = (next_s != ST_STALL);

    pipe_sat_cnt #(.W(8)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stall_clr_s),
        .en  (stall_en_s),
        .cnt (stall_cnt_s)
    );

`ifdef PIPE_SEQ_STATS_EN
    logic flush_entry_s;
    assign flush_entry_s = (next_s == ST_FLUSH);

    pipe_sat_cnt #(.W(STAT_W)) u_stall_stat (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (stall_en_s),
        .cnt (stall_cycles)
    );

    pipe_sat_cnt #(.W(STAT_W)) u_flush_stat (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (flush_entry_s),
        .cnt (flush_events)
    );
`else
    assign stall_cycles = {STAT_W{1'b0}};
    assign flush_events = {STAT_W{1'b0}};
`endif

    assign stage_vld     = stage_vld_r;
    assign stage_en      = stage_en_s;
    assign pc_we         = pc_we_s;
    assign seq_state     = state_r;
    // Masked during reset so a reset on the limit cycle never reports a timeout.
    assign stall_timeout = (state_r == ST_STALL) && !flush_in && stall_hit_s && !rst;
    assign halt_done     = (state_r == ST_HALT) && (stage_vld_r == 5'b00000);

endmodule : pipe_seq_ctrl

// File: tb/tb_pipe_seq_ctrl.sv
// Directed scoreboard bench for pipe_seq_ctrl. Each step drives one cycle of
// inputs and queues the outputs expected during that cycle; a monitor pops
// and compares on the falling edge.
module tb_pipe_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, fetch_vld, freeze_in, flush_in, resolved_in, halt_req;
    logic [4:0]  stage_vld, stage_en;
    logic        pc_we, stall_timeout, halt_done;
    logic [1:0]  seq_state;
    logic [15:0] stall_cycles, flush_events;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  st;
        logic [4:0]  vld;
        logic [4:0]  en;
        logic        pc;
        logic        to;
        logic        hd;
        logic [15:0] sc;
        logic [15:0] fe;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pipe_seq_ctrl #(.STALL_LIMIT(16), .STAT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_vld     (fetch_vld),
        .freeze_in     (freeze_in),
        .flush_in      (flush_in),
        .resolved_in   (resolved_in),
        .halt_req      (halt_req),
        .stage_vld     (stage_vld),
        .stage_en      (stage_en),
        .pc_we         (pc_we),
        .seq_state     (seq_state),
        .stall_timeout (stall_timeout),
        .halt_done     (halt_done),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    // Statistics expectations collapse to zero when the counters are not built.
    function automatic logic [15:0] sx(input int v);
`ifdef PIPE_SEQ_STATS_EN
        return 16'(v);
`else
        return 16'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("seq_state",     {14'd0, seq_state},     {14'd0, e.st});
            chk("stage_vld",     {11'd0, stage_vld},     {11'd0, e.vld});
            chk("stage_en",      {11'd0, stage_en},      {11'd0, e.en});
            chk("pc_we",         {15'd0, pc_we},         {15'd0, e.pc});
            chk("stall_timeout", {15'd0, stall_timeout}, {15'd0, e.to});
            chk("halt_done",     {15'd0, halt_done},     {15'd0, e.hd});
            chk("stall_cycles",  stall_cycles,           e.sc);
            chk("flush_events",  flush_events,           e.fe);
        end
    end

    // One clock of stimulus plus the outputs expected during it.
    task automatic step(input logic r, input logic fv, input logic fz, input logic fl,
                        input logic rs, input logic hr,
                        input logic [1:0] st, input logic [4:0] vld, input logic [4:0] en,
                        input logic pc, input logic to, input logic hd,
                        input int sc, input int fe);
        exp_t e;
        rst = r; fetch_vld = fv; freeze_in = fz; flush_in = fl;
        resolved_in = rs; halt_req = hr;
        e.st = st; e.vld = vld; e.en = en; e.pc = pc; e.to = to; e.hd = hd;
        e.sc = sx(sc); e.fe = sx(fe);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; fetch_vld = 1'b0; freeze_in = 1'b0; flush_in = 1'b0;
        resolved_in = 1'b0; halt_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        step(1,0,0,0,0,0, 2'd0, 5'b00000, 5'b11111, 0,0,0, 0,0);

        // Fill from reset
        step(0,1,0,0,0,0, 2'd0, 5'b00000, 5'b11111, 1,0,0, 0,0);
        step(0,1,0,0,0,0, 2'd0, 5'b00001, 5'b11111, 1,0,0, 0,0);
        step(0,1,0,0,0,0, 2'd0, 5'b00011, 5'b11111, 1,0,0, 0,0);
        step(0,1,0,0,0,0, 2'd0, 5'b00111, 5'b11111, 1,0,0, 0,0);
        step(0,1,0,0,0,0, 2'd0, 5'b01111, 5'b11111, 1,0,0, 0,0);
        step(0,1,0,0,0,0, 2'd0, 5'b11111, 5'b11111, 1,0,0, 0,0);

        // Freeze for three cycles, then resolve
        step(0,1,1,0,0,0, 2'd0, 5'b11111, 5'b11111, 1,0,0, 0,0);
        step(0,1,1,0,0,0, 2'd1, 5'b11111, 5'b11100, 0,0,0, 0,0);
        step(0,1,1,0,0,0, 2'd1, 5'b11011, 5'b11100, 0,0,0, 1,0);
        step(0,1,0,0,1,0, 2'd1, 5'b10011, 5'b11100, 0,0,0, 2,0);
        step(0,1,0,0,0,0, 2'd0, 5'b00011, 5'b11111, 1,0,0, 3,0);
        step(0,1,0,0,0,0, 2'd0, 5'b00111, 5'b11111, 1,0,0, 3,0);
        step(0,1,0,0,0,0, 2'd0, 5'b01111, 5'b11111, 1,0,0, 3,0);

        // Flush and freeze together in RUN: flush wins
        step(0,1,1,1,0,0, 2'd0, 5'b11111, 5'b11111, 1,0,0, 3,0);
        step(0,1,0,0,0,0, 2'd2, 5'b11111, 5'b11111, 1,0,0, 3,1);
        step(0,0,0,0,0,0, 2'd0, 5'b11000, 5'b11111, 0,0,0, 3,1);

        // Freeze held to the stall limit
        step(0,0,1,0,0,0, 2'd0, 5'b10000, 5'b11111, 0,0,0, 3,1);
        for (int k = 1; k <= 16; k++) begin
            step(0,0,1,0,0,0, 2'd1, 5'b00000, 5'b11100, 0, (k == 16), 0, 3 + k - 1, 1);
        end
        step(0,0,1,0,0,0, 2'd2, 5'b00000, 5'b11111, 1,0,0, 19,2);
        step(0,0,0,0,0,0, 2'd0, 5'b00000, 5'b11111, 0,0,0, 19,2);

        // Fill, then halt and drain (freeze ignored while halted)
        step(0,1,0,0,0,0, 2'd0, 5'b00000, 5'b11111, 1,0,0, 19,2);
        step(0,1,0,0,0,0, 2'd0, 5'b00001, 5'b11111, 1,0,0, 19,2);
        step(0,1,0,0,0,0, 2'd0, 5'b00011, 5'b11111, 1,0,0, 19,2);
        step(0,1,0,0,0,0, 2'd0, 5'b00111, 5'b11111, 1,0,0, 19,2);
        step(0,1,0,0,0,0, 2'd0, 5'b01111, 5'b11111, 1,0,0, 19,2);
        step(0,1,0,0,0,1, 2'd0, 5'b11111, 5'b11111, 1,0,0, 19,2);
        step(0,1,1,0,0,1, 2'd3, 5'b11111, 5'b11111, 0,0,0, 19,2);
        step(0,1,1,0,0,1, 2'd3, 5'b11110, 5'b11111, 0,0,0, 19,2);
        step(0,1,1,0,0,1, 2'd3, 5'b11100, 5'b11111, 0,0,0, 19,2);
        step(0,1,1,0,0,1, 2'd3, 5'b11000, 5'b11111, 0,0,0, 19,2);
        step(0,1,1,0,0,1, 2'd3, 5'b10000, 5'b11111, 0,0,0, 19,2);
        step(0,1,0,0,0,0, 2'd3, 5'b00000, 5'b11111, 0,0,1, 19,2);
        step(0,0,0,0,0,0, 2'd0, 5'b00000, 5'b11111, 0,0,0, 19,2);

        // Reset asserted in the middle of a stall
        step(0,1,0,0,0,0, 2'd0, 5'b00000, 5'b11111, 1,0,0, 19,2);
        step(0,1,1,0,0,0, 2'd0, 5'b00001, 5'b11111, 1,0,0, 19,2);
        step(0,1,1,0,0,0, 2'd1, 5'b00011, 5'b11100, 0,0,0, 19,2);
        step(1,1,1,0,0,0, 2'd1, 5'b00011, 5'b11100, 0,0,0, 20,2);
        step(0,0,0,0,0,0, 2'd0, 5'b00000, 5'b11111, 0,0,0, 0,0);

        @(negedge clk);
        #1;
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_seq_ctrl

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 16, meaning the maximum number of consecutive STALL cycles before a forced flush (range 2..255).
REQ-002 SHALL have parameter STAT_W, default 16, meaning the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port fetch_vld, input, 1 bit: a fetched instruction is available.
REQ-006 SHALL have port freeze_in, input, 1 bit: hazard freeze request (from the hazard FSM pc_freeze).
REQ-007 SHALL have port flush_in, input, 1 bit: flush request (from the hazard FSM do_flush).
REQ-008 SHALL have port resolved_in, input, 1 bit: hazard resolved.
REQ-009 SHALL have port halt_req, input, 1 bit: level request to drain and hold the pipe.
REQ-010 SHALL have port stage_vld, output, 5 bits: valid per stage; bit0=IF, bit1=ID, bit2=EX, bit3=MEM, bit4=WB.
REQ-011 SHALL have port stage_en, output, 5 bits: per-stage register enable.
REQ-012 SHALL have port pc_we, output, 1 bit: PC update strobe.
REQ-013 SHALL have port seq_state, output, 2 bits: current state.
REQ-014 SHALL have port stall_timeout, output, 1 bit: one-cycle pulse on a stall-limit flush.
REQ-015 SHALL have port halt_done, output, 1 bit: pipe drained while in HALT.
REQ-016 SHALL have port stall_cycles, output, STAT_W bits: statistics counter.
REQ-017 SHALL have port flush_events, output, STAT_W bits: statistics counter.

Function
REQ-018 SHALL implement a registered FSM with states RUN=0, STALL=1, FLUSH=2, HALT=3; seq_state equals the current state.
REQ-019 RUN SHALL drive stage_en=5'b11111, pc_we=fetch_vld, stage_vld<={stage_vld[3:0],fetch_vld}.
REQ-020 Transition priority from RUN SHALL be flush_in -> FLUSH, then freeze_in -> STALL, then halt_req -> HALT, else RUN.
REQ-021 STALL SHALL drive stage_en=5'b11100 and pc_we=0; on each cycle IF and ID hold, a bubble enters EX (stage_vld[2]<=0), and MEM and WB advance.
REQ-022 STALL SHALL increment the 8-bit stall counter each cycle; the counter clears on entry to any other state.
REQ-023 STALL exit priority SHALL be:
- flush_in -> FLUSH;
- else counter==STALL_LIMIT-1 -> FLUSH, with stall_timeout=1 for that cycle;
- else resolved_in && !freeze_in -> RUN;
- else STALL.
REQ-024 FLUSH SHALL last exactly one cycle and drive pc_we=1 (redirect) and stage_en=5'b11111; it clears stage_vld[2:0] and advances MEM and WB.
REQ-025 On leaving FLUSH, flush_in=1 SHALL give FLUSH again; otherwise the next state is RUN.
REQ-026 HALT SHALL drive pc_we=0 and stage_en=5'b11111 and shift a 0 into IF.
REQ-027 halt_done SHALL equal (state==HALT && stage_vld==0).
REQ-028 Exit from HALT SHALL follow this priority:
- flush_in -> FLUSH;
- else !halt_req -> RUN;
- freeze_in is ignored in HALT.
REQ-029 All outputs SHALL be combinational decodes of registered state, except stage_vld, which is registered.

Reset
REQ-030 rst SHALL force state=RUN, stage_vld=0, the stall counter to 0, and the statistics counters to 0.
REQ-031 rst asserted mid-STALL or mid-HALT SHALL take effect at the next edge with no pulse on stall_timeout.

Configuration
REQ-032 With PIPE_SEQ_STATS_EN defined:
- stall_cycles SHALL count cycles spent in STALL;
- flush_events SHALL count entries into FLUSH;
- both SHALL saturate at all-ones.
REQ-033 With PIPE_SEQ_STATS_EN undefined, stall_cycles and flush_events SHALL be tied to 0 with no counter logic.

Structure
REQ-034 pipe_seq_pkg SHALL hold the state encodings and the stage index constants (IF..WB).
REQ-035 A sub-module pipe_sat_cnt (parameterised width, saturating, enable/clear) SHALL be used for the stall counter and both statistics counters.

Verification
REQ-036 Scenario: fetch_vld=1 for 6 cycles from reset -> stage_vld goes 00001, 00011, … 11111; pc_we=1 each cycle.
REQ-037 Scenario: full pipe, freeze_in=1 for 3 cycles, then resolved_in=1 with freeze_in=0 -> stage_en=11100 for 3 cycles; EX bubble; RUN resumes; stall_cycles=3 (stats build).
REQ-038 Scenario: freeze_in held, STALL_LIMIT=16 -> stall_timeout pulses on the 16th STALL cycle; FLUSH on the next cycle; flush_events=1.
REQ-039 Scenario: flush_in with freeze_in in the same RUN cycle -> FLUSH wins; stage_vld[2:0]=0 and pc_we=1 next cycle.
REQ-040 Scenario: halt_req with full pipe -> halt_done=1 after 5 cycles; release halt_req -> RUN the next cycle.
REQ-041 Scenario: rst asserted mid-STALL -> seq_state=0, stage_vld=0, counters=0 after one edge.
